// File: rtl/demux.sv
// Four-channel demultiplexer with per-channel hold registers and a valid/ack handshake.
// A word goes to the channel picked by ch, or by an internal rotating pointer in sequential mode.
module demux #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       ch,
  input  logic             auto_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic             frame_done
);

  logic [WIDTH-1:0] data_reg [4];
  logic [3:0]       valid_reg;
  logic [1:0]       ptr_reg;
  logic             frame_reg;
  logic [1:0]       target;
  logic             xfer;

  assign target   = auto_en ? ptr_reg : ch;
  // A full channel can still accept when it is being drained in the same cycle.
  assign in_ready = !valid_reg[target] || out_ack[target];
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        data_reg[k] <= '0;
      end
      valid_reg <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (xfer && (target == 2'(k))) begin
          data_reg[k]  <= i;
          valid_reg[k] <= 1'b1;
        end else if (out_ack[k]) begin
          valid_reg[k] <= 1'b0;
        end
      end
    end
  end

  // Leaving sequential mode for even one edge restarts the frame at channel a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= 2'd0;
      frame_reg <= 1'b0;
    end else begin
      frame_reg <= xfer && auto_en && (ptr_reg == 2'd3);
      if (!auto_en) begin
        ptr_reg <= 2'd0;
      end else if (xfer) begin
        ptr_reg <= ptr_reg + 2'd1;
      end
    end
  end

  assign a          = data_reg[0];
  assign b          = data_reg[1];
  assign c          = data_reg[2];
  assign d          = data_reg[3];
  assign out_valid  = valid_reg;
  assign frame_done = frame_reg;

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed vector table, async-reset sequence,
// then randomized traffic compared against an array-based reference model.
module tb_demux;

  logic       clk;
  logic       rst_n;
  logic [3:0] i;
  logic [1:0] ch;
  logic       auto_en;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, c, d;
  logic [3:0] out_valid;
  logic [3:0] out_ack;
  logic       frame_done;

  int checks   = 0;
  int failures = 0;

  demux #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .ch        (ch),
    .auto_en   (auto_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vi;
    logic [1:0] vch;
    logic       vae;
    logic       vv;
    logic [3:0] vack;
    logic       rdy;
    logic [3:0] ea, eb, ec, ed;
    logic [3:0] eov;
    logic       efd;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and all outputs after it.
  task automatic run_cycle(input string name, input vec_t v);
    i        = v.vi;
    ch       = v.vch;
    auto_en  = v.vae;
    in_valid = v.vv;
    out_ack  = v.vack;
    #1;
    chk({name, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk({name, ".a"}, 32'(a), 32'(v.ea));
    chk({name, ".b"}, 32'(b), 32'(v.eb));
    chk({name, ".c"}, 32'(c), 32'(v.ec));
    chk({name, ".d"}, 32'(d), 32'(v.ed));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(v.eov));
    chk({name, ".frame_done"}, 32'(frame_done), 32'(v.efd));
    $display("txn %s i=%h ch=%0d auto=%0b valid=%0b ack=%b -> ready=%0b ov=%b fd=%0b",
             name, v.vi, v.vch, v.vae, v.vv, v.vack, in_ready, out_valid, frame_done);
  endtask

  // Reference model state
  logic [3:0] m_data [4];
  logic       m_val  [4];
  int         m_ptr;
  logic       m_fd;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_data[k] = 4'h0;
      m_val[k]  = 1'b0;
    end
    m_ptr = 0;
    m_fd  = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   tgt;
    logic rdy_m, xfer_m;
    //            i     ch   ae   v    ack     rdy  a     b     c     d     ov       fd
    vecs[0]  = '{4'hF, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0};
    vecs[1]  = '{4'hA, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1, 4'h0, 4'h0, 4'hA, 4'h0, 4'b0100, 1'b0};
    vecs[2]  = '{4'h7, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 4'h0, 4'h7, 4'hA, 4'h0, 4'b0110, 1'b0};
    vecs[3]  = '{4'h9, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'h0, 4'h7, 4'hA, 4'h0, 4'b0110, 1'b0};
    vecs[4]  = '{4'h5, 2'd1, 1'b0, 1'b1, 4'b0010, 1'b1, 4'h0, 4'h5, 4'hA, 4'h0, 4'b0110, 1'b0};
    vecs[5]  = '{4'h0, 2'd0, 1'b0, 1'b0, 4'b0110, 1'b1, 4'h0, 4'h5, 4'hA, 4'h0, 4'b0000, 1'b0};
    vecs[6]  = '{4'h1, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'h1, 4'h5, 4'hA, 4'h0, 4'b0001, 1'b0};
    vecs[7]  = '{4'h2, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'h1, 4'h2, 4'hA, 4'h0, 4'b0011, 1'b0};
    vecs[8]  = '{4'h3, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'h1, 4'h2, 4'h3, 4'h0, 4'b0111, 1'b0};
    vecs[9]  = '{4'h4, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1'b1};
    vecs[10] = '{4'h6, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1'b0};
    vecs[11] = '{4'h6, 2'd0, 1'b1, 1'b1, 4'b0001, 1'b1, 4'h6, 4'h2, 4'h3, 4'h4, 4'b1111, 1'b0};
    vecs[12] = '{4'h0, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b1, 4'h6, 4'h2, 4'h3, 4'h4, 4'b0000, 1'b0};
    vecs[13] = '{4'h8, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'h6, 4'h8, 4'h3, 4'h4, 4'b0010, 1'b0};
    vecs[14] = '{4'h0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'h6, 4'h8, 4'h3, 4'h4, 4'b0010, 1'b0};
    vecs[15] = '{4'h9, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'h9, 4'h8, 4'h3, 4'h4, 4'b0011, 1'b0};
    vecs[16] = '{4'hC, 2'd0, 1'b1, 1'b1, 4'b0000, 1'b0, 4'h9, 4'h8, 4'h3, 4'h4, 4'b0011, 1'b0};
    vecs[17] = '{4'hC, 2'd0, 1'b1, 1'b1, 4'b0010, 1'b1, 4'h9, 4'hC, 4'h3, 4'h4, 4'b0011, 1'b0};

    rst_n = 1'b0; i = '0; ch = '0; auto_en = 1'b0; in_valid = 1'b0; out_ack = '0;
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    chk("reset.abcd", {16'h0, a, b, c, d}, 32'h0);
    chk("reset.frame_done", 32'(frame_done), 32'h0);
    chk("reset.in_ready", 32'(in_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 18; n++) begin
      run_cycle($sformatf("vec%0d", n), vecs[n]);
    end

    // Fill channel d so out_valid = 1011, then pull reset between edges.
    v = '{4'hD, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 4'h9, 4'hC, 4'h3, 4'hD, 4'b1011, 1'b0};
    run_cycle("fill_d", v);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'h0);
    chk("async_rst.abcd", {16'h0, a, b, c, d}, 32'h0);
    chk("async_rst.in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("rst_hold.out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'hE, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'b0001, 1'b0};
    run_cycle("post_rst_seq", v);

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      i        = 4'($urandom);
      ch       = 2'($urandom);
      auto_en  = ($urandom_range(0, 4) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      out_ack  = 4'($urandom & $urandom);
      tgt    = auto_en ? m_ptr : int'(ch);
      rdy_m  = !m_val[tgt] || out_ack[tgt];
      xfer_m = in_valid && rdy_m;
      #1;
      chk("rand.in_ready", 32'(in_ready), 32'(rdy_m));
      m_fd = xfer_m && auto_en && (m_ptr == 3);
      for (int k = 0; k < 4; k++) begin
        if (xfer_m && k == tgt) begin
          m_data[k] = i;
          m_val[k]  = 1'b1;
        end else if (out_ack[k]) begin
          m_val[k] = 1'b0;
        end
      end
      m_ptr = !auto_en ? 0 : (xfer_m ? (m_ptr + 1) % 4 : m_ptr);
      @(posedge clk);
      #1;
      chk("rand.a", 32'(a), 32'(m_data[0]));
      chk("rand.b", 32'(b), 32'(m_data[1]));
      chk("rand.c", 32'(c), 32'(m_data[2]));
      chk("rand.d", 32'(d), 32'(m_data[3]));
      chk("rand.out_valid", 32'(out_valid), 32'({m_val[3], m_val[2], m_val[1], m_val[0]}));
      chk("rand.frame_done", 32'(frame_done), 32'(m_fd));
      if (xfer_m)
        $display("txn rand%0d ch_target=%0d data=%h ov=%b fd=%0b", n, tgt, m_data[tgt], out_valid, frame_done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
